// File: rtl/shreg_pkg.sv
// Shared types and width helpers for the multi-channel shift-register pattern generator.
// Build option: define PARITY_EN to append an even-parity bit to every serialised word.
package shreg_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      SHIFT = 3'd2,
      LATCH = 3'd3,
      GAP   = 3'd4
   } state_t;

`ifdef PARITY_EN
   localparam int PAR_BITS = 1;
`else
   localparam int PAR_BITS = 0;
`endif

   // Counter width able to hold 0..n-1, never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/shreg_fifo.sv
// Word buffer for the pattern generator: power-of-two FIFO with registered ready
// and an occupancy count. Storage is not reset; only pointers and count are.
module shreg_fifo
   import shreg_pkg::*;
#(
   parameter int DW    = 16,
   parameter int DEPTH = 4
) (
   input  logic                       CLK,
   input  logic                       RST_N,
   input  logic                       wr_en,
   input  logic [DW-1:0]              wr_data,
   output logic                       wr_ready,
   input  logic                       rd_en,
   output logic [DW-1:0]              rd_data,
   output logic [$clog2(DEPTH):0]     level
);

   localparam int PW = cnt_w(DEPTH);
   localparam int LW = $clog2(DEPTH) + 1;

   logic [DW-1:0] mem [DEPTH];
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [LW-1:0] count_q, count_d;
   logic          wr_ready_q;
   logic          push, pop;

   assign push = wr_en && wr_ready_q;
   assign pop  = rd_en && (count_q != '0);

   always_comb begin
      count_d = count_q;
      if (push && !pop)
         count_d = count_q + 1'b1;
      else if (!push && pop)
         count_d = count_q - 1'b1;
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         wr_ready_q <= 1'b1;
      end else begin
         if (push)
            wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)
            rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q    <= count_d;
         wr_ready_q <= (count_d != LW'(DEPTH));
      end
   end

   always_ff @(posedge CLK) begin
      if (push)
         mem[wr_ptr_q] <= wr_data;
   end

   assign rd_data  = mem[rd_ptr_q];
   assign wr_ready = wr_ready_q;
   assign level    = count_q;

endmodule

// File: rtl/shreg_pattern_gen.sv
// Buffers NCH-channel words and shifts them MSB first onto parallel shift-register chains,
// followed by a latch strobe and an idle gap. Build option: PARITY_EN adds a parity bit.
module shreg_pattern_gen
   import shreg_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int NCH     = 2,
   parameter int DEPTH   = 4,
   parameter int GAP_CYC = 2
) (
   input  logic                     CLK,
   input  logic                     RST_N,
   input  logic                     wr_valid,
   input  logic [NCH*WIDTH-1:0]     wr_data,
   output logic                     wr_ready,
   input  logic                     run,
   output logic [NCH-1:0]           sdout,
   output logic                     ENdin,
   output logic                     load_pulse,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int SL = WIDTH + PAR_BITS;
   localparam int BW = cnt_w(SL);
   localparam int GW = cnt_w(GAP_CYC);

   state_t               state_q;
   logic [BW-1:0]        bit_q;
   logic [GW-1:0]        gap_q;
   logic [NCH-1:0]       sdout_q;
   logic                 en_q, load_q, busy_q;
   logic [SL-1:0]        shreg_q  [NCH];
   logic [SL-1:0]        load_val [NCH];
   logic [NCH*WIDTH-1:0] head;
   logic                 pop, go;

   assign pop = (state_q == LOAD);
   assign go  = run && (level != '0);

   shreg_fifo #(
      .DW    (NCH*WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .CLK      (CLK),
      .RST_N    (RST_N),
      .wr_en    (wr_valid),
      .wr_data  (wr_data),
      .wr_ready (wr_ready),
      .rd_en    (pop),
      .rd_data  (head),
      .level    (level)
   );

   always_comb begin
      for (int c = 0; c < NCH; c++) begin
`ifdef PARITY_EN
         load_val[c] = {head[c*WIDTH +: WIDTH], ^head[c*WIDTH +: WIDTH]};
`else
         load_val[c] = head[c*WIDTH +: WIDTH];
`endif
      end
   end

   // Shift data path carries no reset; it is always reloaded in LOAD before use.
   always_ff @(posedge CLK) begin
      for (int c = 0; c < NCH; c++) begin
         if (state_q == LOAD)
            shreg_q[c] <= load_val[c];
         else if (state_q == SHIFT)
            shreg_q[c] <= shreg_q[c] << 1;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q <= IDLE;
         bit_q   <= '0;
         gap_q   <= '0;
         sdout_q <= '0;
         en_q    <= 1'b0;
         load_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         sdout_q <= '0;
         en_q    <= 1'b0;
         load_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (go) begin
                  state_q <= LOAD;
                  busy_q  <= 1'b1;
               end else begin
                  busy_q  <= 1'b0;
               end
            end
            LOAD: begin
               bit_q   <= BW'(SL-1);
               state_q <= SHIFT;
            end
            SHIFT: begin
               for (int c = 0; c < NCH; c++)
                  sdout_q[c] <= shreg_q[c][SL-1];
               en_q <= 1'b1;
               if (bit_q == '0)
                  state_q <= LATCH;
               else
                  bit_q <= bit_q - 1'b1;
            end
            LATCH: begin
               load_q <= 1'b1;
               if (GAP_CYC > 0) begin
                  state_q <= GAP;
                  gap_q   <= GW'(GAP_CYC-1);
               end else if (go) begin
                  state_q <= LOAD;
               end else begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
            GAP: begin
               if (gap_q != '0) begin
                  gap_q <= gap_q - 1'b1;
               end else if (go) begin
                  state_q <= LOAD;
               end else begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign sdout      = sdout_q;
   assign ENdin      = en_q;
   assign load_pulse = load_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_shreg_pattern_gen.sv
// Directed bench for shreg_pattern_gen at WIDTH=8, NCH=2, DEPTH=4, GAP_CYC=2.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_shreg_pattern_gen;

   localparam int WIDTH   = 8;
   localparam int NCH     = 2;
   localparam int DEPTH   = 4;
   localparam int GAP_CYC = 2;
`ifdef PARITY_EN
   localparam int PB = 1;
`else
   localparam int PB = 0;
`endif
   localparam int SL     = WIDTH + PB;
   localparam int PERIOD = 1 + SL + 1 + GAP_CYC;

   logic                   CLK = 1'b0;
   logic                   RST_N = 1'b0;
   logic                   wr_valid = 1'b0;
   logic [NCH*WIDTH-1:0]   wr_data = '0;
   logic                   run = 1'b0;
   logic                   wr_ready;
   logic [NCH-1:0]         sdout;
   logic                   ENdin;
   logic                   load_pulse;
   logic                   busy;
   logic [$clog2(DEPTH):0] level;

   int vecs = 0;
   int errs = 0;

   shreg_pattern_gen #(
      .WIDTH   (WIDTH),
      .NCH     (NCH),
      .DEPTH   (DEPTH),
      .GAP_CYC (GAP_CYC)
   ) dut (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .wr_valid   (wr_valid),
      .wr_data    (wr_data),
      .wr_ready   (wr_ready),
      .run        (run),
      .sdout      (sdout),
      .ENdin      (ENdin),
      .load_pulse (load_pulse),
      .busy       (busy),
      .level      (level)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vecs++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_en(output int w);
      w = 0;
      while (ENdin !== 1'b1 && w < 40) begin
         @(negedge CLK);
         w++;
      end
   endtask

   // Collects one serialised word; optionally drops run after sampling bit drop_at.
   task automatic grab(input int drop_at, output logic [15:0] w, output logic [1:0] par,
                       output int n);
      w = '0; par = '0; n = 0;
      while (ENdin === 1'b1 && n < 20) begin
         if (n < WIDTH) begin
            w[7:0]  = {w[6:0],  sdout[0]};
            w[15:8] = {w[14:8], sdout[1]};
         end else begin
            par = sdout;
         end
         if (n == drop_at) run = 1'b0;
         n++;
         @(negedge CLK);
      end
   endtask

   task automatic push(input logic [15:0] d);
      wr_valid = 1'b1;
      wr_data  = d;
      @(negedge CLK);
      wr_valid = 1'b0;
   endtask

   initial begin
      logic [15:0] words [5];
      logic [15:0] w;
      logic [1:0]  par;
      int          n, lat, seen;

      words[0] = 16'h1234; words[1] = 16'hABCD; words[2] = 16'h0F0F;
      words[3] = 16'hC3E1; words[4] = 16'hFFFF;

      // 1: reset held while inputs are active
      RST_N = 1'b0; run = 1'b1; wr_valid = 1'b1; wr_data = 16'hFFFF;
      repeat (3) @(negedge CLK);
      check("rst_sdout", sdout, 0);
      check("rst_endin", ENdin, 0);
      check("rst_load",  load_pulse, 0);
      check("rst_busy",  busy, 0);
      check("rst_level", level, 0);
      check("rst_ready", wr_ready, 1);

      // 2: single word A5_3C
      RST_N = 1'b1; wr_valid = 1'b0; run = 1'b0;
      @(negedge CLK);
      wr_valid = 1'b1; wr_data = 16'hA53C; run = 1'b1;
      @(negedge CLK);
      wr_valid = 1'b0;
      wait_en(lat);
      check("t2_latency", lat, 3);
      check("t2_busy_shift", busy, 1);
      grab(-1, w, par, n);
      check("t2_nbits", n, SL);
      check("t2_ch0", w[7:0], 8'h3C);
      check("t2_ch1", w[15:8], 8'hA5);
      check("t2_load", load_pulse, 1);
      check("t2_load_en", ENdin, 0);
      check("t2_load_sd", sdout, 0);
      @(negedge CLK);
      check("t2_gap_load", load_pulse, 0);
      check("t2_gap_en", ENdin, 0);
      check("t2_gap_sd", sdout, 0);
      @(negedge CLK);
      check("t2_idle_busy", busy, 0);
      check("t2_idle_load", load_pulse, 0);

      // 3: fill past full, then stream back to back
      run = 1'b0;
      wr_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         wr_data = words[k];
         @(negedge CLK);
      end
      wr_valid = 1'b0;
      check("t3_full_level", level, 4);
      check("t3_full_ready", wr_ready, 0);
      run = 1'b1;
      wait_en(lat);
      check("t3_latency", lat, 3);
      for (int k = 0; k < 4; k++) begin
         if (k > 0) begin
            wait_en(lat);
            check($sformatf("t3_period%0d", k), n + lat, PERIOD);
         end
         grab(-1, w, par, n);
         check($sformatf("t3_word%0d", k), w, words[k]);
         check($sformatf("t3_load%0d", k), load_pulse, 1);
         check($sformatf("t3_level%0d", k), level, 3 - k);
      end
      repeat (2) @(negedge CLK);
      check("t3_end_busy", busy, 0);
      check("t3_end_level", level, 0);
      check("t3_end_ready", wr_ready, 1);

      // 4: run dropped mid-word
      run = 1'b0;
      push(16'h8001);
      push(16'h7E55);
      check("t4_level2", level, 2);
      run = 1'b1;
      wait_en(lat);
      grab(3, w, par, n);
      check("t4_word", w, 16'h8001);
      check("t4_load", load_pulse, 1);
      repeat (2) @(negedge CLK);
      check("t4_busy", busy, 0);
      check("t4_level", level, 1);
      repeat (5) @(negedge CLK);
      check("t4_no_start", ENdin, 0);
      check("t4_level_kept", level, 1);

      // 5: reset in the middle of a word
      push(16'h1E2D);
      check("t5_level2", level, 2);
      run = 1'b1;
      wait_en(lat);
      repeat (5) @(negedge CLK);
      check("t5_bit5_en", ENdin, 1);
      RST_N = 1'b0;
      @(negedge CLK);
      check("t5_en", ENdin, 0);
      check("t5_sd", sdout, 0);
      check("t5_level", level, 0);
      check("t5_busy", busy, 0);
      check("t5_ready", wr_ready, 1);
      RST_N = 1'b1;
      run = 1'b0;
      seen = 0;
      repeat (4) begin
         if (load_pulse === 1'b1) seen++;
         @(negedge CLK);
      end
      check("t5_no_load", seen, 0);

`ifdef PARITY_EN
      // 6: parity bit appended per channel
      push(16'h0701);
      run = 1'b1;
      wait_en(lat);
      grab(-1, w, par, n);
      check("t6_nbits", n, 9);
      check("t6_word", w, 16'h0701);
      check("t6_parity", par, 2'b11);
      run = 1'b0;
      repeat (3) @(negedge CLK);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule
